// File: rtl/formula_2_sched_pkg.sv
// Shared types for the time-multiplexed isqrt(a + isqrt(b + isqrt(c))) scheduler.
package formula_2_sched_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        PASS_C = 2'd0,
        PASS_B = 2'd1,
        PASS_A = 2'd2
    } pass_t;

    typedef struct packed {
        pass_t             pass;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } meta_t;

endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based FIFO with occupancy counter and first-word fall-through read data.
module flip_flop_fifo_with_counter #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign pop_data = mem_q[rd_q];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign count    = cnt_q;

    assert property (@(posedge clk) disable iff (rst) !(pop && empty));
    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/isqrt.sv
// Pipelined digit-by-digit integer square root; latency N_STAGES cycles, 16 iterations spread
// evenly over the stages.
module isqrt #(
    parameter int unsigned N_STAGES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);
    localparam int unsigned N_ITER = 16;

    typedef struct packed {
        logic        vld;
        logic [31:0] x;
        logic [19:0] rem;
        logic [15:0] root;
    } stage_t;

    stage_t st_in [N_STAGES];
    stage_t st_d  [N_STAGES];
    stage_t st_q  [N_STAGES];

    function automatic int unsigned iters(input int unsigned s);
        return ((s + 1) * N_ITER) / N_STAGES - (s * N_ITER) / N_STAGES;
    endfunction

    function automatic stage_t step(input stage_t st, input int unsigned n);
        stage_t      r;
        logic [19:0] trial;
        r     = st;
        trial = '0;
        for (int unsigned i = 0; i < N_ITER; i++) begin
            if (i < n) begin
                r.rem = {r.rem[17:0], r.x[31:30]};
                r.x   = {r.x[29:0], 2'b00};
                trial = {2'b00, r.root, 2'b01};
                if (r.rem >= trial) begin
                    r.rem  = r.rem - trial;
                    r.root = {r.root[14:0], 1'b1};
                end else begin
                    r.root = {r.root[14:0], 1'b0};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        st_in[0] = '{vld: x_vld, x: x, rem: '0, root: '0};
        for (int s = 1; s < N_STAGES; s++) begin
            st_in[s] = st_q[s-1];
        end
        for (int s = 0; s < N_STAGES; s++) begin
            st_d[s] = step(st_in[s], iters(s));
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < N_STAGES; s++) begin
            st_q[s] <= st_d[s];
            if (rst) begin
                st_q[s].vld <= 1'b0;
            end
        end
    end

    assign y_vld = st_q[N_STAGES-1].vld;
    assign y     = st_q[N_STAGES-1].root;

endmodule

// File: rtl/formula_2_shared_isqrt_sched.sv
// res = isqrt(a + isqrt(b + isqrt(c))) on one shared isqrt, three passes per job.
// Optional perf counters: define FORMULA_2_SHARED_ISQRT_SCHED_PERF_EN.
module formula_2_shared_isqrt_sched
    import formula_2_sched_pkg::*;
#(
    parameter int unsigned ISQRT_N_STAGES = 8,
    parameter int unsigned META_DEPTH     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arg_vld,
    output logic              arg_rdy,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic              res_vld,
    output logic [DATA_W-1:0] res
`ifdef FORMULA_2_SHARED_ISQRT_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_jobs_done,
    output logic [31:0]       perf_stall_cycles
`endif
);
    localparam int unsigned CNT_W  = $clog2(META_DEPTH + 1);
    localparam int unsigned META_W = $bits(meta_t);

    if (META_DEPTH < ISQRT_N_STAGES) begin : g_depth_check
        $error("META_DEPTH must be >= ISQRT_N_STAGES");
    end

    logic              y_vld;
    logic [15:0]       y;
    logic [DATA_W-1:0] y_ext;
    logic              x_vld;
    logic [DATA_W-1:0] x;
    meta_t             push_meta;
    meta_t             pop_meta;
    logic [META_W-1:0] pop_bits;
    logic              meta_full;
    logic              meta_empty;
    logic [CNT_W-1:0]  meta_count;
    logic              recirc;
    logic              accept;
    logic              done;
    logic              res_vld_q;
    logic [DATA_W-1:0] res_q;

    assign pop_meta = meta_t'(pop_bits);
    assign y_ext    = DATA_W'(y);

    // Recirculation owns the issue slot; new jobs only take it when it is free.
    always_comb begin
        recirc    = !rst && y_vld && (pop_meta.pass != PASS_A);
        done      = !rst && y_vld && (pop_meta.pass == PASS_A);
        arg_rdy   = !rst && !recirc && !meta_full;
        accept    = arg_vld && arg_rdy;
        x_vld     = recirc || accept;
        x         = c;
        push_meta = '{pass: PASS_C, a: a, b: b};
        if (recirc) begin
            push_meta.a = pop_meta.a;
            push_meta.b = pop_meta.b;
            if (pop_meta.pass == PASS_C) begin
                x              = y_ext + pop_meta.b;
                push_meta.pass = PASS_B;
            end else begin
                x              = y_ext + pop_meta.a;
                push_meta.pass = PASS_A;
            end
        end
    end

    isqrt #(
        .N_STAGES (ISQRT_N_STAGES)
    ) u_isqrt (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld),
        .y     (y)
    );

    flip_flop_fifo_with_counter #(
        .WIDTH (META_W),
        .DEPTH (META_DEPTH)
    ) u_meta_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (x_vld),
        .push_data (push_meta),
        .pop       (y_vld),
        .pop_data  (pop_bits),
        .empty     (meta_empty),
        .full      (meta_full),
        .count     (meta_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            res_vld_q <= done;
            if (done) begin
                res_q <= y_ext;
            end
        end
    end

    assign res_vld = res_vld_q;
    assign res     = res_q;

    assert property (@(posedge clk) disable iff (rst) !(y_vld && meta_empty));
    assert property (@(posedge clk) disable iff (rst) meta_count <= CNT_W'(ISQRT_N_STAGES));

`ifdef FORMULA_2_SHARED_ISQRT_SCHED_PERF_EN
    logic [31:0] jobs_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_q  <= '0;
            stall_q <= '0;
        end else begin
            if (res_vld_q) begin
                jobs_q <= jobs_q + 1'b1;
            end
            if (arg_vld && !arg_rdy) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign perf_jobs_done    = jobs_q;
    assign perf_stall_cycles = stall_q;
`endif

endmodule
